// File: rtl/servo_sweep_pwm.sv
// servo_sweep_pwm
//   Radar servo stage. Generates a framed servo PWM from a microsecond tick
//   and sweeps the commanded angle back and forth across 0..MAX_DEG. At each
//   settled angle it raises a measurement request and waits for the ranging
//   stage to acknowledge before stepping to the next angle.
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous, active-low reset
//   tick_us     in   one-clk strobe per microsecond; all PWM timing counts it
//   enable      in   1 = sweep runs, 0 = hold current angle
//   meas_done   in   one-clk strobe: measurement for presented angle finished
//   pwm         out  servo control signal (registered)
//   angle       out  current commanded angle, degrees
//   angle_valid out  measurement request; angle is stable and settled
//   sweep_dir   out  0 = increasing, 1 = decreasing
module servo_sweep_pwm #(
  parameter int unsigned PERIOD_US     = 20000,
  parameter int unsigned MIN_PULSE_US  = 500,
  parameter int unsigned US_PER_DEG    = 11,
  parameter int unsigned STEP_DEG      = 10,
  parameter int unsigned MAX_DEG       = 180,
  parameter int unsigned SETTLE_FRAMES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_us,
  input  logic       enable,
  input  logic       meas_done,
  output logic       pwm,
  output logic [7:0] angle,
  output logic       angle_valid,
  output logic       sweep_dir
);

  localparam int unsigned SW = (SETTLE_FRAMES < 2) ? 1 : $clog2(SETTLE_FRAMES);

  typedef enum logic [1:0] {IDLE, SETTLE, REQ, STEP} state_e;

  state_e        state_q, state_d;
  logic [14:0]   frame_q, frame_d;
  logic [15:0]   pw_q, pw_d;
  logic [15:0]   pw_calc;
  logic          pwm_q;
  logic [SW-1:0] settle_q, settle_d;
  logic [7:0]    angle_q, angle_d;
  logic          dir_q, dir_d;
  logic          wrap;

  // Frame counter and pulse width; width only changes on the wrap tick so a
  // frame is never cut short or stretched mid-pulse.
  always_comb begin
    wrap    = tick_us && (frame_q == 15'(PERIOD_US - 1));
    frame_d = frame_q;
    if (tick_us) frame_d = wrap ? '0 : frame_q + 15'd1;
    pw_calc = 16'(MIN_PULSE_US) + 16'(angle_q) * 16'(US_PER_DEG);
    pw_d    = wrap ? pw_calc : pw_q;
  end

  // Sweep FSM. Disable overrides everything, including a same-cycle meas_done.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    angle_d  = angle_q;
    dir_d    = dir_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = SETTLE;
          settle_d = '0;
        end
        SETTLE: begin
          // settle_q counts completed wraps; the SETTLE_FRAMES-th wrap moves on.
          if (wrap) begin
            if (settle_q == SW'(SETTLE_FRAMES - 1)) state_d = REQ;
            else settle_d = settle_q + SW'(1);
          end
        end
        REQ: begin
          if (meas_done) state_d = STEP;
        end
        STEP: begin
          if (!dir_q) begin
            angle_d = angle_q + 8'(STEP_DEG);
            if (angle_d == 8'(MAX_DEG)) dir_d = 1'b1;
          end else begin
            angle_d = angle_q - 8'(STEP_DEG);
            if (angle_d == '0) dir_d = 1'b0;
          end
          state_d  = SETTLE;
          settle_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      pw_q     <= 16'(MIN_PULSE_US);
      pwm_q    <= 1'b0;
      settle_q <= '0;
      angle_q  <= '0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      pw_q     <= pw_d;
      pwm_q    <= ({1'b0, frame_q} < pw_q);
      settle_q <= settle_d;
      angle_q  <= angle_d;
      dir_q    <= dir_d;
    end
  end

  assign pwm         = pwm_q;
  assign angle       = angle_q;
  assign angle_valid = (state_q == REQ);
  assign sweep_dir   = dir_q;

endmodule

// File: doc/servo_sweep_pwm.md
# servo_sweep_pwm

Radar servo stage, directly downstream of the microsecond tick divider. Consumes a one-cycle `tick_us` strobe and generates the 50 Hz servo PWM. Sweeps the servo angle back and forth across 0..MAX_DEG in fixed steps. At each settled position it hands the angle to the ultrasonic ranging stage and waits for that stage's completion handshake before moving on.

## Interface
- `PERIOD_US`, 20000, PWM frame length in ticks.
- `MIN_PULSE_US`, 500, pulse width at angle 0.
- `US_PER_DEG`, 11, added pulse width per degree.
- `STEP_DEG`, 10, angle increment per sweep step; must divide MAX_DEG.
- `MAX_DEG`, 180, sweep upper bound; ≤ 255.
- `SETTLE_FRAMES`, 10, full PWM frames to wait after each angle change before requesting a measurement; ≥ 1.
- `clk`  in  1  system clock; only clock in the block.
- `reset`  in  1  synchronous, active-low reset.
- `tick_us`  in  1  one-`clk` strobe, once per microsecond; all PWM timing counts these.
- `enable`  in  1  level; 1 = sweep runs, 0 = hold current angle.
- `meas_done`  in  1  one-cycle strobe from the ranging stage: measurement for the presented angle finished.
- `pwm`  out  1  servo control signal, registered.
- `angle`  out  8  current commanded angle in degrees, 0..MAX_DEG.
- `angle_valid`  out  1  measurement request; `angle` is stable and settled.
- `sweep_dir`  out  1  0 = increasing, 1 = decreasing.

## Operation
- Frame counter, 15 bits:
  - Advances by 1 on each `tick_us`.
  - Wraps from PERIOD_US-1 to 0.
  - Holds between ticks.
- Pulse width is `MIN_PULSE_US + angle*US_PER_DEG`, computed at 16 bits, no saturation. Defaults give a maximum of 2480.
- Pulse width is latched into `pw_q` only on the wrap tick, so a width change never takes effect mid-frame.
- Each cycle, `pwm <= (frame_cnt < pw_q)`. PWM runs continuously after reset, independent of the FSM and of `enable`.
- FSM states: IDLE, SETTLE, REQ, STEP.
  - IDLE: go to SETTLE when `enable`=1, with the settle frame count cleared.
  - SETTLE: count frame wraps. After SETTLE_FRAMES wraps, go to REQ and assert `angle_valid`.
  - REQ: hold `angle_valid`=1 and a stable `angle` until `meas_done`=1, then go to STEP. `angle_valid` drops on the same edge.
  - STEP: a single cycle that updates `angle` and `sweep_dir`, then goes to SETTLE with the settle count cleared.
- Angle update in STEP:
  - `sweep_dir`=0: `angle += STEP_DEG`.
    - If the new angle equals MAX_DEG, set `sweep_dir`=1.
  - `sweep_dir`=1: `angle -= STEP_DEG`.
    - If the new angle equals 0, set `sweep_dir`=0.
  - Endpoints 0 and MAX_DEG are each measured once per pass; the sweep never exceeds the bounds.
- `enable`=0 in any state:
  - Next state is IDLE and `angle_valid` drops next edge.
  - `angle` and `sweep_dir` hold; PWM keeps driving the held angle.
  - Re-enabling restarts SETTLE at the held angle.
- `meas_done` outside REQ is ignored.
- `meas_done` and `enable`=0 in the same cycle: `enable` wins, so the state goes to IDLE and the angle does not advance.

## Timing
- Reset values (`reset`=0 at a `clk` edge):
  - `pwm`=0, `angle`=0, `angle_valid`=0, `sweep_dir`=0.
  - Frame count = 0, `pw_q`=MIN_PULSE_US, state IDLE.
- Reset asserted mid-operation returns everything to these values on that edge, including an outstanding request, which is abandoned.
- `pwm` lags the frame counter by one `clk`. With frame_cnt=0 and `pw_q`>0, `pwm` is 1 from the cycle after the wrap tick until the cycle after the tick where frame_cnt reaches `pw_q`. High time is exactly `pw_q` ticks.
- First request after `enable` rises is asserted one `clk` after the SETTLE_FRAMES-th wrap tick.
- `meas_done` to next-angle `pwm` effect: the STEP update happens 2 `clk` after `meas_done`. The new width applies from the next frame wrap.
- `angle_valid` deasserts 1 `clk` after `meas_done`.
- A `tick_us` coinciding with a state change is still counted.

## Test plan
- Reset, then `tick_us` every 4th `clk`, PERIOD_US=100, MIN_PULSE_US=10, US_PER_DEG=1, `enable`=0 -> `pwm` is high for 10 ticks per 100-tick frame; `angle` stays 0 and `angle_valid` stays 0.
- `enable`=1, SETTLE_FRAMES=2 -> `angle_valid` rises 1 `clk` after the 2nd wrap tick with `angle`=0. Pulse `meas_done` -> `angle_valid` falls next `clk`; `angle`=10 two `clk` after `meas_done`; `pwm` width of 20 starts at the next frame.
- Respond to every request, MAX_DEG=30, STEP_DEG=10 -> the sequence of presented angles is 0,10,20,30,20,10,0,10; `sweep_dir` toggles when `angle` reaches 30 and when it returns to 0.
- `meas_done` pulsed while in SETTLE -> no effect on `angle` or the settle count.
- `enable` and `meas_done` deasserted/asserted in the same cycle during REQ -> state goes to IDLE and `angle` is unchanged. Re-enable -> a new request for the same angle appears after SETTLE_FRAMES frames.
- `reset` pulsed during REQ with `angle`=20 -> all outputs return to their reset values on that edge; the frame counter restarts at 0.
